// File: rtl/eth_tx_pkt_buf_pkg.sv
// Shared types for the Ethernet TX store-and-forward frame buffer:
// AXI-Stream request/response structs, the per-beat buffer entry and the
// write-side FSM state encoding.
package eth_tx_pkt_buf_pkg;

    localparam int unsigned AxisDataWidth = 64;
    localparam int unsigned AxisKeepWidth = AxisDataWidth / 8;
    localparam int unsigned AxisUserWidth = 1;
    localparam int unsigned AxisIdWidth   = 1;
    localparam int unsigned AxisDestWidth = 1;
    localparam int unsigned DropCntWidth  = 16;

    typedef struct packed {
        logic [AxisDataWidth-1:0] tdata;
        logic [AxisKeepWidth-1:0] tstrb;
        logic [AxisKeepWidth-1:0] tkeep;
        logic                     tlast;
        logic [AxisIdWidth-1:0]   tid;
        logic [AxisDestWidth-1:0] tdest;
        logic [AxisUserWidth-1:0] tuser;
        logic                     tvalid;
    } axi_stream_req_t;

    typedef struct packed {
        logic tready;
    } axi_stream_rsp_t;

    // One stored beat; tstrb/tid/tdest are not kept.
    typedef struct packed {
        logic [AxisDataWidth-1:0] tdata;
        logic [AxisKeepWidth-1:0] tkeep;
        logic                     tlast;
        logic [AxisUserWidth-1:0] tuser;
    } buf_entry_t;

    typedef enum logic {
        WRITE = 1'b0,
        DROP  = 1'b1
    } wr_state_e;

endpackage

// File: rtl/eth_tx_pkt_buf_mem.sv
// Flop-based dual-port storage for the TX frame buffer: synchronous write,
// combinational read, generic over the stored entry type.
module eth_tx_pkt_buf_mem #(
    parameter type         entry_t = logic,
    parameter int unsigned Depth   = 256,
    parameter int unsigned AddrWidth = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 wr_en_i,
    input  logic [AddrWidth-1:0] wr_addr_i,
    input  entry_t               wr_data_i,
    input  logic [AddrWidth-1:0] rd_addr_i,
    output entry_t               rd_data_o
);

    entry_t mem_q [Depth];

    // Store one entry per cycle when enabled; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/eth_tx_pkt_buffer.sv
// Store-and-forward AXI-Stream frame buffer in front of the Ethernet framing
// wrapper TX input. A frame is only presented downstream once its tlast beat
// is stored; frames that do not fit are dropped whole.
// Optional statistics counters: define ETH_TX_PKT_BUF_STATS_EN.
//
// Handshake: on both AXI-Stream interfaces a beat transfers on a rising clock
// edge where tvalid and tready are both high; tvalid never waits on tready,
// and once the output raises tvalid its payload is held until the transfer.
module eth_tx_pkt_buffer
    import eth_tx_pkt_buf_pkg::*;
#(
    parameter type         s_req_t   = axi_stream_req_t,
    parameter type         s_rsp_t   = axi_stream_rsp_t,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned UserWidth = 1,
    parameter int unsigned Depth     = 256,
    parameter int unsigned MaxPkts   = 16,
    parameter int unsigned CntWidth  = $clog2(MaxPkts + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  s_req_t                  tx_axis_req_i,
    output s_rsp_t                  tx_axis_rsp_o,
    output s_req_t                  tx_axis_req_o,
    input  s_rsp_t                  tx_axis_rsp_i,
    output logic [CntWidth-1:0]     pkt_cnt_o,
    output logic [DropCntWidth-1:0] drop_cnt_o,
    output logic [31:0]             frame_cnt_o
);

    localparam int unsigned AddrWidth = $clog2(Depth);
    localparam int unsigned PtrWidth  = AddrWidth + 1;
    localparam int unsigned KeepWidth = DataWidth / 8;

    localparam logic [PtrWidth-1:0] PtrOne    = PtrWidth'(1);
    localparam logic [PtrWidth-1:0] DepthPtr  = PtrWidth'(Depth);
    localparam logic [CntWidth-1:0] CntOne    = CntWidth'(1);
    localparam logic [CntWidth-1:0] MaxPktCnt = CntWidth'(MaxPkts);

    // Pointers carry one extra MSB so that full and empty are distinguishable.
    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0] commit_ptr_q, commit_ptr_d;
    logic [PtrWidth-1:0] rd_ptr_q;
    logic [PtrWidth-1:0] used;
    logic [CntWidth-1:0] pkt_cnt_q;
    wr_state_e           state_q, state_d;

    logic       full;
    logic       in_ready;
    logic       in_fire;
    logic       out_valid;
    logic       out_fire;
    logic       out_last_fire;
    logic       mem_we;
    logic       commit;
    logic       drop_done;
    buf_entry_t wr_entry;
    buf_entry_t rd_entry;
    logic       unused_in_fields;

    assign used      = wr_ptr_q - rd_ptr_q;
    assign full      = (used == DepthPtr);
    // While discarding a frame the input keeps draining regardless of pkt_cnt.
    assign in_ready  = (state_q == DROP) || (pkt_cnt_q < MaxPktCnt);
    assign in_fire   = tx_axis_req_i.tvalid && in_ready;
    assign out_valid = (pkt_cnt_q != '0);
    assign out_fire  = out_valid && tx_axis_rsp_i.tready;
    assign out_last_fire = out_fire && rd_entry.tlast;

    assign unused_in_fields = ^{tx_axis_req_i.tstrb, tx_axis_req_i.tid,
                                tx_axis_req_i.tdest};

    // Capture the incoming beat fields that are kept in the buffer.
    always_comb begin
        wr_entry       = '0;
        wr_entry.tdata = tx_axis_req_i.tdata[DataWidth-1:0];
        wr_entry.tkeep = tx_axis_req_i.tkeep[KeepWidth-1:0];
        wr_entry.tlast = tx_axis_req_i.tlast;
        wr_entry.tuser = tx_axis_req_i.tuser[UserWidth-1:0];
    end

    // Write FSM: store, commit on tlast, or rewind and discard on overflow.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        mem_we       = 1'b0;
        commit       = 1'b0;
        drop_done    = 1'b0;
        case (state_q)
            WRITE: begin
                if (in_fire) begin
                    if (full) begin
                        // Only uncommitted entries are given back; a frame
                        // whose overflowing beat is also its last is dropped
                        // on the spot so the next frame is not swallowed.
                        wr_ptr_d = commit_ptr_q;
                        if (tx_axis_req_i.tlast) begin
                            drop_done = 1'b1;
                        end else begin
                            state_d = DROP;
                        end
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PtrOne;
                        if (tx_axis_req_i.tlast) begin
                            commit       = 1'b1;
                            commit_ptr_d = wr_ptr_q + PtrOne;
                        end
                    end
                end
            end
            DROP: begin
                if (in_fire && tx_axis_req_i.tlast) begin
                    drop_done = 1'b1;
                    state_d   = WRITE;
                end
            end
            default: state_d = WRITE;
        endcase
    end

    // Write-side state, pointers and committed-frame count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= WRITE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            pkt_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            // A commit and a completed send in one cycle cancel out.
            case ({commit, out_last_fire})
                2'b10:   pkt_cnt_q <= pkt_cnt_q + CntOne;
                2'b01:   pkt_cnt_q <= pkt_cnt_q - CntOne;
                default: pkt_cnt_q <= pkt_cnt_q;
            endcase
        end
    end

    // Read pointer advances on every output transfer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
        end else if (out_fire) begin
            rd_ptr_q <= rd_ptr_q + PtrOne;
        end
    end

    eth_tx_pkt_buf_mem #(
        .entry_t (buf_entry_t),
        .Depth   (Depth)
    ) u_mem (
        .clk_i     (clk_i),
        .wr_en_i   (mem_we),
        .wr_addr_i (wr_ptr_q[AddrWidth-1:0]),
        .wr_data_i (wr_entry),
        .rd_addr_i (rd_ptr_q[AddrWidth-1:0]),
        .rd_data_o (rd_entry)
    );

    // Drive the output stream straight from the head entry.
    always_comb begin
        tx_axis_req_o        = '0;
        tx_axis_req_o.tvalid = out_valid;
        tx_axis_req_o.tdata  = rd_entry.tdata;
        tx_axis_req_o.tkeep  = rd_entry.tkeep;
        tx_axis_req_o.tlast  = rd_entry.tlast;
        tx_axis_req_o.tuser  = rd_entry.tuser;
    end

    // Input-side ready toward the host.
    always_comb begin
        tx_axis_rsp_o        = '0;
        tx_axis_rsp_o.tready = in_ready;
    end

    assign pkt_cnt_o = pkt_cnt_q;

`ifdef ETH_TX_PKT_BUF_STATS_EN
    logic [DropCntWidth-1:0] drop_cnt_q;
    logic [31:0]             frame_cnt_q;

    // Saturating drop counter and wrapping sent-frame counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            if (drop_done && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + DropCntWidth'(1);
            end
            if (out_last_fire) begin
                frame_cnt_q <= frame_cnt_q + 32'd1;
            end
        end
    end

    assign drop_cnt_o  = drop_cnt_q;
    assign frame_cnt_o = frame_cnt_q;
`else
    logic unused_drop_done;

    assign unused_drop_done = drop_done;
    assign drop_cnt_o       = '0;
    assign frame_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_eth_tx_pkt_buffer.sv
// Self-checking bench for eth_tx_pkt_buffer (Depth=16, MaxPkts=4).
// Counter expectations follow ETH_TX_PKT_BUF_STATS_EN.
module tb_eth_tx_pkt_buffer;
    import eth_tx_pkt_buf_pkg::*;

    localparam int Depth   = 16;
    localparam int MaxPkts = 4;
    localparam int CntW    = $clog2(MaxPkts + 1);
    localparam int W       = 74;   // {tdata, tkeep, tlast, tuser}

    typedef struct {
        int         n_beats;
        logic [7:0] last_keep;
        bit         exp_pass;
    } frame_vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    axi_stream_req_t host_req;
    axi_stream_rsp_t host_rsp;
    axi_stream_req_t wrap_req;
    axi_stream_rsp_t wrap_rsp;
    logic [CntW-1:0] pkt_cnt;
    logic [15:0]     drop_cnt;
    logic [31:0]     frame_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [W-1:0] exp_q[$];
    int          exp_frames = 0;
    int          exp_drops = 0;
    int          frame_id = 0;
    int          hs_count = 0;
    bit          saw_valid = 0;
    bit          prev_stall = 0;
    logic [W-1:0] prev_beat;
    logic [W-1:0] mon_beat;
    frame_vec_t  vecs[6];

    eth_tx_pkt_buffer #(
        .Depth   (Depth),
        .MaxPkts (MaxPkts)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .tx_axis_req_i (host_req),
        .tx_axis_rsp_o (host_rsp),
        .tx_axis_req_o (wrap_req),
        .tx_axis_rsp_i (wrap_rsp),
        .pkt_cnt_o     (pkt_cnt),
        .drop_cnt_o    (drop_cnt),
        .frame_cnt_o   (frame_cnt)
    );

    // ---------------- clock / watchdog ----------------
    always #4 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] make_beat(input int id, input int b, input int n,
                                               input logic [7:0] last_keep);
        logic [63:0] d;
        logic        last;
        d    = {16'hFEED, 16'(id), 16'hC0DE, 16'(b)};
        last = (b == n - 1);
        return {d, (last ? last_keep : 8'hFF), last, 1'(b)};
    endfunction

    function automatic logic [31:0] exp_frame_val();
`ifdef ETH_TX_PKT_BUF_STATS_EN
        return 32'(exp_frames);
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [15:0] exp_drop_val();
`ifdef ETH_TX_PKT_BUF_STATS_EN
        return 16'(exp_drops);
`else
        return 16'd0;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_beat(input logic [W-1:0] beat);
        int guard;
        bit acc;
        guard = 0;
        acc   = 0;
        host_req.tvalid = 1'b1;
        host_req.tdata  = beat[73:10];
        host_req.tkeep  = beat[9:2];
        host_req.tlast  = beat[1];
        host_req.tuser  = beat[0];
        while (!acc && guard < 300) begin
            @(negedge clk);
            acc = host_rsp.tready;
            @(posedge clk);
            #1;
            guard++;
        end
        host_req.tvalid = 1'b0;
        if (!acc) begin
            n_checks++;
            n_errors++;
            $display("FAIL beat_accept: input tready never high, required accept within 300 cycles");
        end
    endtask

    task automatic send_frame(input int n, input logic [7:0] last_keep, input bit pass);
        int id;
        id = frame_id;
        frame_id++;
        if (pass) begin
            for (int b = 0; b < n; b++) exp_q.push_back(make_beat(id, b, n, last_keep));
        end
        for (int b = 0; b < n; b++) drive_beat(make_beat(id, b, n, last_keep));
    endtask

    task automatic wait_drain(input string name);
        int guard;
        guard = 0;
        while ((pkt_cnt != 0 || exp_q.size() != 0) && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        n_checks++;
        if (guard >= 500) begin
            n_errors++;
            $display("FAIL %s: pkt_cnt=%0d pending=%0d after 500 cycles, required 0/0",
                     name, pkt_cnt, exp_q.size());
        end
    endtask

    task automatic check_counts(input string name);
        check({name, "_pkt_cnt"}, 80'(pkt_cnt), 80'(0));
        check({name, "_frame_cnt"}, 80'(frame_cnt), 80'(exp_frame_val()));
        check({name, "_drop_cnt"}, 80'(drop_cnt), 80'(exp_drop_val()));
    endtask

    // ---------------- scoreboard / monitor ----------------
    // Sampled on the falling edge: a beat seen valid&ready here transfers on
    // the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            mon_beat = {wrap_req.tdata, wrap_req.tkeep, wrap_req.tlast, wrap_req.tuser};
            if (wrap_req.tvalid) saw_valid = 1;
            if (prev_stall) begin
                check("stall_tvalid", 80'(wrap_req.tvalid), 80'(1));
                check("stall_beat", 80'(mon_beat), 80'(prev_beat));
            end
            if (wrap_req.tvalid && wrap_rsp.tready) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL out_beat: got unexpected beat %0h, required none", mon_beat);
                end else begin
                    check("out_beat", 80'(mon_beat), 80'(exp_q.pop_front()));
                end
                check("out_zero_fields", 80'({wrap_req.tstrb, wrap_req.tid, wrap_req.tdest}), 80'(0));
            end
            prev_stall = wrap_req.tvalid && !wrap_rsp.tready;
            prev_beat  = mon_beat;
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        int id;
        int guard;

        vecs[0] = '{n_beats: 1,  last_keep: 8'h01, exp_pass: 1'b1};
        vecs[1] = '{n_beats: 3,  last_keep: 8'hFF, exp_pass: 1'b1};
        vecs[2] = '{n_beats: 16, last_keep: 8'h80, exp_pass: 1'b1};
        vecs[3] = '{n_beats: 20, last_keep: 8'hFF, exp_pass: 1'b0};
        vecs[4] = '{n_beats: 17, last_keep: 8'h03, exp_pass: 1'b0};
        vecs[5] = '{n_beats: 5,  last_keep: 8'h3F, exp_pass: 1'b1};

        host_req = '0;
        wrap_rsp = '0;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset values
        check("rst_out_tvalid", 80'(wrap_req.tvalid), 80'(0));
        check("rst_in_tready", 80'(host_rsp.tready), 80'(1));
        check_counts("rst");

        // Single 8-beat frame: tvalid rises the cycle after tlast is accepted
        wrap_rsp.tready = 1'b1;
        id = frame_id;
        frame_id++;
        for (int b = 0; b < 8; b++) exp_q.push_back(make_beat(id, b, 8, 8'h0F));
        for (int b = 0; b < 7; b++) drive_beat(make_beat(id, b, 8, 8'h0F));
        check("single_pre_last_tvalid", 80'(wrap_req.tvalid), 80'(0));
        check("single_pre_last_pkt_cnt", 80'(pkt_cnt), 80'(0));
        drive_beat(make_beat(id, 7, 8, 8'h0F));
        check("single_commit_tvalid", 80'(wrap_req.tvalid), 80'(1));
        check("single_commit_pkt_cnt", 80'(pkt_cnt), 80'(1));
        exp_frames++;
        wait_drain("single_drain");
        check_counts("single");

        // Back-pressure: fill to MaxPkts, hold, release one frame
        wrap_rsp.tready = 1'b0;
        for (int f = 0; f < 4; f++) send_frame(2, 8'hFF, 1'b1);
        check("maxpkts_in_tready", 80'(host_rsp.tready), 80'(0));
        check("maxpkts_pkt_cnt", 80'(pkt_cnt), 80'(4));
        repeat (20) @(posedge clk);
        #1;
        check("held_tvalid", 80'(wrap_req.tvalid), 80'(1));
        check("held_beat", 80'({wrap_req.tdata, wrap_req.tkeep, wrap_req.tlast, wrap_req.tuser}),
              80'(exp_q[0]));
        wrap_rsp.tready = 1'b1;
        guard = 0;
        while (pkt_cnt != 3 && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        wrap_rsp.tready = 1'b0;
        check("recover_pkt_cnt", 80'(pkt_cnt), 80'(3));
        check("recover_in_tready", 80'(host_rsp.tready), 80'(1));
        wrap_rsp.tready = 1'b1;
        exp_frames += 4;
        wait_drain("bp_drain");
        check_counts("bp");

        // Overflow: held 10-beat frame, second 10-beat frame dropped, 6-beat fits
        wrap_rsp.tready = 1'b0;
        send_frame(10, 8'h07, 1'b1);
        send_frame(10, 8'hFF, 1'b0);
        exp_drops++;
        check("ovf_pkt_cnt", 80'(pkt_cnt), 80'(1));
        check("ovf_drop_cnt", 80'(drop_cnt), 80'(exp_drop_val()));
        check("ovf_in_tready", 80'(host_rsp.tready), 80'(1));
        send_frame(6, 8'h1F, 1'b1);
        check("ovf_fit_pkt_cnt", 80'(pkt_cnt), 80'(2));
        wrap_rsp.tready = 1'b1;
        exp_frames += 2;
        wait_drain("ovf_drain");
        check_counts("ovf");

        // Table-driven frames into an empty buffer, output always ready
        wrap_rsp.tready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            saw_valid = 0;
            send_frame(vecs[v].n_beats, vecs[v].last_keep, vecs[v].exp_pass);
            if (vecs[v].exp_pass) exp_frames++;
            else exp_drops++;
            wait_drain($sformatf("vec%0d_drain", v));
            check_counts($sformatf("vec%0d", v));
            if (!vecs[v].exp_pass) check($sformatf("vec%0d_no_tvalid", v), 80'(saw_valid), 80'(0));
        end

        // Last beat of A sent in the same cycle B commits
        wrap_rsp.tready = 1'b0;
        send_frame(2, 8'hFF, 1'b1);
        id = frame_id;
        frame_id++;
        for (int b = 0; b < 4; b++) exp_q.push_back(make_beat(id, b, 4, 8'h3F));
        drive_beat(make_beat(id, 0, 4, 8'h3F));
        drive_beat(make_beat(id, 1, 4, 8'h3F));
        wrap_rsp.tready = 1'b1;
        drive_beat(make_beat(id, 2, 4, 8'h3F));
        drive_beat(make_beat(id, 3, 4, 8'h3F));
        check("simul_pkt_cnt", 80'(pkt_cnt), 80'(1));
        check("simul_no_gap_tvalid", 80'(wrap_req.tvalid), 80'(1));
        check("simul_no_gap_beat", 80'({wrap_req.tdata, wrap_req.tkeep, wrap_req.tlast, wrap_req.tuser}),
              80'(make_beat(id, 0, 4, 8'h3F)));
        exp_frames += 2;
        wait_drain("simul_drain");
        check_counts("simul");

        // Reset pulsed while beat 3 of an 8-beat frame is on the output
        wrap_rsp.tready = 1'b0;
        send_frame(8, 8'hFF, 1'b1);
        hs_count = 0;
        wrap_rsp.tready = 1'b1;
        guard = 0;
        while (hs_count < 3 && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("mid_reset_beats_sent", 80'(hs_count), 80'(3));
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_frames = 0;
        exp_drops  = 0;
        check("mid_reset_tvalid", 80'(wrap_req.tvalid), 80'(0));
        check_counts("mid_reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_in_tready", 80'(host_rsp.tready), 80'(1));
        send_frame(8, 8'h3F, 1'b1);
        exp_frames++;
        wait_drain("post_reset_drain");
        check_counts("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
